// File: rtl/adc_pulse_sampler.sv
`default_nettype none
// ============================================================================
// Module   : adc_pulse_sampler
// Brief    : Delays an RF-ADC beat stream, averages a lane window per beat and
//            presents it with a run-gated strobe plus saturation/underrun stats.
// Revision : 1.0 - initial release
// ============================================================================
module adc_pulse_sampler #(
  parameter int NUM_BITS  = 16,
  parameter int SPC       = 8,
  parameter int DEL_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BITS*SPC-1:0]      adc_tdata,
  input  logic                         adc_tvalid,
  input  logic                         run,
  input  logic [$clog2(SPC)-1:0]       lane_sel,
  input  logic [1:0]                   avg_log2,
  input  logic [$clog2(DEL_DEPTH)-1:0] cycle_del,
  output logic [NUM_BITS-1:0]          val_out,
  output logic                         val_valid,
  output logic [15:0]                  sat_count,
  output logic [15:0]                  underrun_count,
  output logic                         running
);

  localparam int SPC_LOG2 = $clog2(SPC);
  localparam int DEL_LOG2 = $clog2(DEL_DEPTH);
  localparam int CNT_W    = SPC_LOG2 + 1;
  // Wide enough that a full-width window of extreme samples cannot wrap.
  localparam int SUM_W    = NUM_BITS + SPC_LOG2;

  localparam logic [1:0]          c_max_log2 = (SPC_LOG2 > 3) ? 2'd3 : 2'(SPC_LOG2);
  localparam logic [CNT_W-1:0]    c_spc      = CNT_W'(SPC);
  localparam logic [NUM_BITS-1:0] c_pos_full = {1'b0, {(NUM_BITS-1){1'b1}}};
  localparam logic [NUM_BITS-1:0] c_neg_full = {1'b1, {(NUM_BITS-1){1'b0}}};

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_run  = 1'b1;

  logic [0:0]                r_state;
  logic [0:0]                w_state_next;
  logic                      w_enter_run;
  logic                      w_cfg_load;
  logic                      w_in_run;

  logic [SPC_LOG2-1:0]       r_lane_sel;
  logic [1:0]                r_avg_log2;
  logic [DEL_LOG2-1:0]       r_cycle_del;

  logic [NUM_BITS*SPC-1:0]   r_dl_data [DEL_DEPTH];
  logic [DEL_DEPTH-1:0]      r_dl_valid;
  logic [NUM_BITS*SPC-1:0]   w_tap_data;
  logic                      w_tap_valid;

  logic [1:0]                w_nlog2;
  logic [CNT_W-1:0]          w_n;
  logic [CNT_W-1:0]          w_lim;
  logic [SPC_LOG2-1:0]       w_start;
  logic [SPC-1:0]            w_mask;
  logic signed [SUM_W-1:0]   w_sum;
  logic [CNT_W-1:0]          w_sat;

  logic signed [SUM_W-1:0]   r_sum;
  logic [1:0]                r_shift;
  logic                      r_sum_valid;
  logic [NUM_BITS-1:0]       w_avg;

  logic [16:0]               w_sat_acc;
  logic [16:0]               w_und_acc;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_idle;
    else      r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (run)  w_state_next = c_run;
      c_run:   if (!run) w_state_next = c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  // State-derived controls
  always_comb begin
    w_in_run    = (r_state == c_run);
    w_enter_run = (r_state == c_idle) && run;
    w_cfg_load  = (r_state == c_idle) && !run;
    running     = w_in_run;
  end

  // Config shadows freeze from the edge that enters RUN onwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane_sel  <= '0;
      r_avg_log2  <= '0;
      r_cycle_del <= '0;
    end else if (w_cfg_load) begin
      r_lane_sel  <= lane_sel;
      r_avg_log2  <= avg_log2;
      r_cycle_del <= cycle_del;
    end
  end

  // Entry 0 doubles as the input stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEL_DEPTH; i++) r_dl_data[i] <= '0;
      r_dl_valid <= '0;
    end else begin
      r_dl_data[0] <= adc_tdata;
      for (int i = 1; i < DEL_DEPTH; i++) r_dl_data[i] <= r_dl_data[i-1];
      r_dl_valid <= {r_dl_valid[DEL_DEPTH-2:0], adc_tvalid};
    end
  end

  assign w_tap_data  = r_dl_data[r_cycle_del];
  assign w_tap_valid = r_dl_valid[r_cycle_del];

  always_comb begin
    w_nlog2 = (r_avg_log2 > c_max_log2) ? c_max_log2 : r_avg_log2;
    w_n     = CNT_W'(1) << w_nlog2;
    w_lim   = c_spc - w_n;
    w_start = ({1'b0, r_lane_sel} > w_lim) ? w_lim[SPC_LOG2-1:0] : r_lane_sel;
    w_mask  = ~({SPC{1'b1}} << w_n) << w_start;
  end

  always_comb begin
    w_sum = '0;
    w_sat = '0;
    for (int k = 0; k < SPC; k++) begin
      if (w_mask[k]) begin
        w_sum = w_sum + SUM_W'($signed(w_tap_data[k*NUM_BITS +: NUM_BITS]));
        if ((w_tap_data[k*NUM_BITS +: NUM_BITS] == c_pos_full) ||
            (w_tap_data[k*NUM_BITS +: NUM_BITS] == c_neg_full))
          w_sat = w_sat + CNT_W'(1);
      end
    end
  end

  // The shift travels with its sum so late config changes cannot skew it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum       <= '0;
      r_shift     <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum       <= w_sum;
      r_shift     <= w_nlog2;
      r_sum_valid <= w_tap_valid;
    end
  end

  assign w_avg = NUM_BITS'(r_sum >>> r_shift);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_out   <= '0;
      val_valid <= 1'b0;
    end else begin
      val_out   <= w_avg;
      val_valid <= w_in_run && r_sum_valid;
    end
  end

  assign w_sat_acc = {1'b0, sat_count} + 17'(w_sat);
  assign w_und_acc = {1'b0, underrun_count} + 17'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_count      <= '0;
      underrun_count <= '0;
    end else if (w_enter_run) begin
      sat_count      <= '0;
      underrun_count <= '0;
    end else if (w_in_run) begin
      if (w_tap_valid)
        sat_count <= w_sat_acc[16] ? 16'hFFFF : w_sat_acc[15:0];
      else
        underrun_count <= w_und_acc[16] ? 16'hFFFF : w_und_acc[15:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_pulse_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_pulse_sampler
// Brief    : Randomised and directed bench for adc_pulse_sampler against a
//            cycle-indexed behavioural model of stream history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_pulse_sampler;

  localparam int NB  = 16;
  localparam int SPC = 8;
  localparam int DD  = 16;
  localparam int HN  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB*SPC-1:0] adc_tdata = '0;
  logic          adc_tvalid = 1'b0;
  logic          run = 1'b0;
  logic [2:0]    lane_sel = '0;
  logic [1:0]    avg_log2 = '0;
  logic [3:0]    cycle_del = '0;
  logic [NB-1:0] val_out;
  logic          val_valid;
  logic [15:0]   sat_count;
  logic [15:0]   underrun_count;
  logic          running;

  always #5 clk = ~clk;

  adc_pulse_sampler #(.NUM_BITS(NB), .SPC(SPC), .DEL_DEPTH(DD)) dut (
    .clk(clk), .rst(rst), .adc_tdata(adc_tdata), .adc_tvalid(adc_tvalid),
    .run(run), .lane_sel(lane_sel), .avg_log2(avg_log2), .cycle_del(cycle_del),
    .val_out(val_out), .val_valid(val_valid), .sat_count(sat_count),
    .underrun_count(underrun_count), .running(running)
  );

  // Stimulus as sampled at edge n, and model state after edge n.
  bit [NB*SPC-1:0] h_data [HN];
  bit h_valid [HN];
  bit h_run   [HN];
  bit h_rst   [HN];
  int h_ls [HN], h_al [HN], h_cd [HN];
  bit m_st [HN];
  int m_ls [HN], m_al [HN], m_cd [HN];

  int e = 0, checks = 0, fails = 0, last_rst = 0;
  int m_sat = 0, m_und = 0, exp_out = 0;
  bit exp_valid = 1'b0;
  int pulses = 0, pulse_edge = 0;
  bit g_run = 1'b0, g_rst = 1'b0;
  int g_ls = 0, g_al = 0, g_cd = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, act, exp);
    end
  endtask

  function automatic int lane(input bit [NB*SPC-1:0] d, input int k);
    int v;
    v = $signed(d[k*NB +: NB]);
    return v;
  endfunction

  function automatic int win_n(input int al);
    return 1 << ((al > 3) ? 3 : al);
  endfunction

  function automatic int win_s(input int ls, input int al);
    return (ls > SPC - win_n(al)) ? SPC - win_n(al) : ls;
  endfunction

  // Mean of the window, rounded toward minus infinity.
  function automatic int avg_of(input bit [NB*SPC-1:0] d, input int ls, input int al);
    int n, s, sum;
    n = win_n(al);
    s = win_s(ls, al);
    sum = 0;
    for (int k = s; k < s + n; k++) sum += lane(d, k);
    if (sum >= 0) return sum / n;
    return -((-sum + n - 1) / n);
  endfunction

  function automatic int sat_of(input bit [NB*SPC-1:0] d, input int ls, input int al);
    int c, s;
    c = 0;
    s = win_s(ls, al);
    for (int k = s; k < s + win_n(al); k++)
      if (lane(d, k) == 32767 || lane(d, k) == -32768) c++;
    return c;
  endfunction

  // A beat survives only if it was captured after the most recent reset.
  function automatic bit live(input int b);
    return (b >= 1) && (b > last_rst);
  endfunction

  function automatic bit [NB*SPC-1:0] lanes_of(input int base);
    bit [NB*SPC-1:0] d;
    for (int k = 0; k < SPC; k++) d[k*NB +: NB] = 16'(base + k);
    return d;
  endfunction

  function automatic bit [NB*SPC-1:0] rand_beat();
    bit [NB*SPC-1:0] d;
    int r;
    for (int k = 0; k < SPC; k++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      d[k*NB +: NB] = 16'h7FFF;
      else if (r == 1) d[k*NB +: NB] = 16'h8000;
      else if (r == 2) d[k*NB +: NB] = 16'hFFFF;
      else             d[k*NB +: NB] = 16'($urandom);
    end
    return d;
  endfunction

  always @(posedge clk) begin
    int b, d, s;
    e = e + 1;
    if (h_rst[e]) begin
      m_st[e] = 1'b0; m_ls[e] = 0; m_al[e] = 0; m_cd[e] = 0;
      m_sat = 0; m_und = 0; last_rst = e;
      exp_out = 0; exp_valid = 1'b0;
    end else begin
      d = m_cd[e-1];
      b = e - 1 - d;
      if (!m_st[e-1] && h_run[e]) begin
        m_sat = 0; m_und = 0;
      end else if (m_st[e-1]) begin
        if (live(b) && h_valid[b]) begin
          s = m_sat + sat_of(h_data[b], m_ls[e-1], m_al[e-1]);
          m_sat = (s > 65535) ? 65535 : s;
        end else begin
          m_und = (m_und >= 65535) ? 65535 : m_und + 1;
        end
      end
      exp_out = 0; exp_valid = 1'b0;
      if (e >= 2) begin
        d = m_cd[e-2];
        b = e - 2 - d;
        if (live(b)) begin
          exp_out   = avg_of(h_data[b], m_ls[e-2], m_al[e-2]);
          exp_valid = m_st[e-1] && h_valid[b];
        end
      end
      m_st[e] = h_run[e];
      if (!m_st[e-1] && !h_run[e]) begin
        m_ls[e] = h_ls[e]; m_al[e] = h_al[e]; m_cd[e] = h_cd[e];
      end else begin
        m_ls[e] = m_ls[e-1]; m_al[e] = m_al[e-1]; m_cd[e] = m_cd[e-1];
      end
    end
  end

  always @(negedge clk) begin
    if (e >= 1 && rst) begin
      chk("val_valid", int'(val_valid), int'(exp_valid));
      if (exp_valid) chk("val_out", int'($signed(val_out)), exp_out);
      chk("running", int'(running), int'(m_st[e]));
      chk("sat_count", int'(sat_count), m_sat);
      chk("underrun_count", int'(underrun_count), m_und);
      if (val_valid) begin
        pulses++;
        pulse_edge = e;
      end
    end
  end

  task automatic step(input bit [NB*SPC-1:0] d, input bit v);
    adc_tdata  = d;
    adc_tvalid = v;
    run        = g_run;
    lane_sel   = 3'(g_ls);
    avg_log2   = 2'(g_al);
    cycle_del  = 4'(g_cd);
    h_data[e+1] = d;  h_valid[e+1] = v;  h_run[e+1] = g_run;  h_rst[e+1] = g_rst;
    h_ls[e+1] = g_ls; h_al[e+1] = g_al; h_cd[e+1] = g_cd;
    if (g_rst) begin
      if (rst) begin
        rst = 1'b0;
        #1;
        chk("rst_val_out", int'(val_out), 0);
        chk("rst_val_valid", int'(val_valid), 0);
        chk("rst_sat", int'(sat_count), 0);
        chk("rst_underrun", int'(underrun_count), 0);
        chk("rst_running", int'(running), 0);
      end
    end else begin
      rst = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [NB*SPC-1:0] bt;
    int t0, n_idle, n_run;

    // Model pins with hand-computed values.
    bt = '0;
    bt[4*NB +: NB] = 16'hFFFF; bt[5*NB +: NB] = 16'hFFFE;
    bt[6*NB +: NB] = 16'hFFFE; bt[7*NB +: NB] = 16'hFFFE;
    chk("pin_clamped_avg", avg_of(bt, 6, 2), -2);
    chk("pin_lane_pick", avg_of(lanes_of(500), 2, 0), 502);
    bt = '0; bt[0 +: NB] = 16'h7FFF; bt[NB +: NB] = 16'h8000;
    chk("pin_sat_pair", sat_of(bt, 0, 1), 2);
    chk("pin_floor_half", avg_of(bt, 0, 1), -1);
    chk("pin_full_window", avg_of({SPC{16'h7FFF}}, 3, 3), 32767);

    g_rst = 1'b1;
    repeat (3) step(rand_beat(), 1'b1);
    g_rst = 1'b0;

    // Lane pick
    g_run = 0; g_cd = 0; g_ls = 2; g_al = 0;
    repeat (4) step(lanes_of(100 * (e % 300)), 1'b1);
    g_run = 1;
    repeat (2) step(lanes_of(100 * (e % 300)), 1'b1);
    t0 = e;
    repeat (3) step(lanes_of(100 * (e % 300)), 1'b1);
    chk("lane_pick_val", int'($signed(val_out)), 100 * (t0 % 300) + 2);
    chk("lane_pick_valid", int'(val_valid), 1);

    // Clamped average, observed in IDLE
    g_run = 0;
    repeat (2) step(rand_beat(), 1'b1);
    g_ls = 6; g_al = 2;
    bt = rand_beat();
    bt[4*NB +: NB] = 16'hFFFF; bt[5*NB +: NB] = 16'hFFFE;
    bt[6*NB +: NB] = 16'hFFFE; bt[7*NB +: NB] = 16'hFFFE;
    step(bt, 1'b1);
    repeat (2) step(rand_beat(), 1'b1);
    chk("clamped_avg", int'($signed(val_out)), -2);

    // Delay with a single marker beat; cycle_del change in RUN is ignored
    g_cd = 5; g_ls = 0; g_al = 0;
    repeat (20) step('0, 1'b0);
    pulses = 0;
    g_run = 1;
    repeat (5) step('0, 1'b0);
    t0 = e;
    step(lanes_of(1234), 1'b1);
    repeat (2) step('0, 1'b0);
    g_cd = 2;
    repeat (15) step('0, 1'b0);
    chk("delay_pulses", pulses, 1);
    chk("delay_edge", pulse_edge, t0 + 3 + 5);

    // Underrun gap
    g_run = 0; g_cd = 0;
    repeat (6) step(rand_beat(), 1'b1);
    g_run = 1;
    repeat (6) step(rand_beat(), 1'b1);
    repeat (4) step(rand_beat(), 1'b0);
    repeat (6) step(rand_beat(), 1'b1);
    chk("gap_underrun", int'(underrun_count), 4);
    g_run = 0;
    repeat (3) step(rand_beat(), 1'b1);
    g_run = 1;
    repeat (3) step(rand_beat(), 1'b1);
    chk("gap_cleared", int'(underrun_count), 0);

    // Saturation in RUN, then the same beat in IDLE
    g_run = 0; g_ls = 0; g_al = 1;
    repeat (5) step('0, 1'b1);
    g_run = 1;
    repeat (3) step('0, 1'b1);
    bt = '0; bt[0 +: NB] = 16'h7FFF; bt[NB +: NB] = 16'h8000;
    step(bt, 1'b1);
    repeat (4) step('0, 1'b1);
    chk("sat_run", int'(sat_count), 2);
    g_run = 0;
    repeat (3) step('0, 1'b1);
    step(bt, 1'b1);
    repeat (4) step('0, 1'b1);
    chk("sat_idle_hold", int'(sat_count), 2);

    // Randomised segments with one reset mid-RUN
    for (int seg = 0; seg < 12; seg++) begin
      g_run = 0;
      g_ls = $urandom_range(0, 7); g_al = $urandom_range(0, 3); g_cd = $urandom_range(0, 15);
      n_idle = $urandom_range(3, 10);
      for (int i = 0; i < n_idle; i++) step(rand_beat(), $urandom_range(0, 9) != 0);
      g_run = 1;
      n_run = $urandom_range(20, 80);
      for (int i = 0; i < n_run; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          g_ls = $urandom_range(0, 7); g_al = $urandom_range(0, 3); g_cd = $urandom_range(0, 15);
        end
        g_rst = (seg == 6 && i == n_run / 2);
        step(rand_beat(), $urandom_range(0, 99) < 85);
      end
      g_rst = 1'b0;
    end
    g_run = 0;
    repeat (20) step(rand_beat(), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
